// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA single-port memory arbiter.
// The optional starvation guard is controlled by MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_CPU = 2'd1,
      RD_DMA = 2'd2
   } rd_state_e;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   localparam int MAX_WAIT_DEFAULT = 4;
   localparam int WAIT_CNT_W       = 4;

   // Read-return state that follows a grant given to owner o this cycle.
   function automatic rd_state_e next_rd_state(owner_e o, logic cpu_rd, logic dma_rd);
      rd_state_e s;
      s = IDLE;
      if (o == OWN_CPU && cpu_rd) s = RD_CPU;
      if (o == OWN_DMA && dma_rd) s = RD_DMA;
      return s;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU port, DMA port and the shared RAM port.
// slave = arbiter side, master = the agents/RAM surrounding it.
interface mem_arbiter_if;

   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_wdata_i;
   logic        cpu_we_i;
   logic        cpu_re_i;
   logic [2:0]  cpu_size_i;
   logic [31:0] cpu_rdata_o;
   logic        cpu_hold_o;

   logic        dma_req_i;
   logic        dma_we_i;
   logic [31:0] dma_addr_i;
   logic [31:0] dma_wdata_i;
   logic [2:0]  dma_size_i;
   logic        dma_gnt_o;
   logic        dma_rvalid_o;
   logic [31:0] dma_rdata_o;

   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic        ram_we_o;
   logic        ram_re_o;
   logic [2:0]  ram_size_o;
   logic [31:0] ram_rdata_i;

   modport slave (
      input  cpu_addr_i, cpu_wdata_i, cpu_we_i, cpu_re_i, cpu_size_i,
      output cpu_rdata_o, cpu_hold_o,
      input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dma_size_i,
      output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      output ram_addr_o, ram_wdata_o, ram_we_o, ram_re_o, ram_size_o,
      input  ram_rdata_i
   );

   modport master (
      output cpu_addr_i, cpu_wdata_i, cpu_we_i, cpu_re_i, cpu_size_i,
      input  cpu_rdata_o, cpu_hold_o,
      output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i, dma_size_i,
      input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
      input  ram_addr_o, ram_wdata_o, ram_we_o, ram_re_o, ram_size_o,
      output ram_rdata_i
   );

endinterface

// File: rtl/arb_wait_cnt.sv
// Saturating count of cycles a DMA request has been blocked; flags a forced
// grant once the count reaches MAX_WAIT. Used only with MEM_ARB_STARVE_GUARD_EN.
module arb_wait_cnt
   import mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic                  gnt_i,
   output logic [WAIT_CNT_W-1:0] cnt_o,
   output logic                  force_o
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);
   localparam logic [WAIT_CNT_W-1:0] CNT_MAX    = '1;

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!req_i || gnt_i) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign force_o = req_i && (cnt_q == WAIT_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for a single RAM port with 1-cycle read latency; CPU has
// priority unless MEM_ARB_STARVE_GUARD_EN forces a grant to a starved DMA.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
      $error("mem_arbiter: MAX_WAIT must be within 1..15");
   end

   logic      cpu_req;
   logic      dma_req;
   logic      dma_force;
   owner_e    owner;
   rd_state_e state_q;
   rd_state_e state_d;

   assign cpu_req = bus.cpu_we_i | bus.cpu_re_i;
   assign dma_req = bus.dma_req_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [WAIT_CNT_W-1:0] wait_cnt;

   arb_wait_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk     (clk),
      .rst     (rst),
      .req_i   (dma_req),
      .gnt_i   (owner == OWN_DMA),
      .cnt_o   (wait_cnt),
      .force_o (dma_force)
   );
`else
   assign dma_force = 1'b0;
`endif

   // Gating on rst keeps every output at zero for the whole reset window.
   always_comb begin
      owner = OWN_NONE;
      if (rst) begin
         if (dma_req && dma_force) begin
            owner = OWN_DMA;
         end else if (cpu_req) begin
            owner = OWN_CPU;
         end else if (dma_req) begin
            owner = OWN_DMA;
         end
      end
   end

   always_comb begin
      bus.ram_addr_o  = '0;
      bus.ram_wdata_o = '0;
      bus.ram_size_o  = '0;
      bus.ram_we_o    = 1'b0;
      bus.ram_re_o    = 1'b0;
      case (owner)
         OWN_CPU: begin
            bus.ram_addr_o  = bus.cpu_addr_i;
            bus.ram_wdata_o = bus.cpu_wdata_i;
            bus.ram_size_o  = bus.cpu_size_i;
            bus.ram_we_o    = bus.cpu_we_i;
            bus.ram_re_o    = bus.cpu_re_i;
         end
         OWN_DMA: begin
            bus.ram_addr_o  = bus.dma_addr_i;
            bus.ram_wdata_o = bus.dma_wdata_i;
            bus.ram_size_o  = bus.dma_size_i;
            bus.ram_we_o    = bus.dma_we_i;
            bus.ram_re_o    = !bus.dma_we_i;
         end
         default: ;
      endcase
   end

   assign bus.cpu_hold_o = cpu_req && (owner != OWN_CPU) && rst;
   assign bus.dma_gnt_o  = (owner == OWN_DMA);

   // The read-return state tracks who owns the data arriving next cycle.
   always_comb begin
      state_d = next_rd_state(owner, bus.cpu_re_i, !bus.dma_we_i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus.cpu_rdata_o  = (state_q == RD_CPU) ? bus.ram_rdata_i : 32'h0;
   assign bus.dma_rvalid_o = (state_q == RD_DMA);
   assign bus.dma_rdata_o  = (state_q == RD_DMA) ? bus.ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency RAM model; the
// starvation section follows MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   mem_arbiter_if bus();

   mem_arbiter #(.MAX_WAIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // RAM model: unwritten words read back as 0xA000_0000 | byte address.
   logic [31:0] mem     [0:1023];
   logic        written [0:1023];
   logic        mem_init = 1'b0;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
         mem_init <= 1'b1;
      end else begin
         if (bus.ram_we_o) begin
            mem[bus.ram_addr_o[11:2]]     <= bus.ram_wdata_o;
            written[bus.ram_addr_o[11:2]] <= 1'b1;
         end
         if (bus.ram_re_o) begin
            bus.ram_rdata_i <= written[bus.ram_addr_o[11:2]] ? mem[bus.ram_addr_o[11:2]]
                                                              : (32'hA000_0000 | {20'h0, bus.ram_addr_o[11:0]});
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %-14s got=%08h", tag, got);
      end
   endtask

   task automatic idle_all();
      bus.cpu_we_i = 1'b0; bus.cpu_re_i = 1'b0; bus.cpu_addr_i = '0;
      bus.cpu_wdata_i = '0; bus.cpu_size_i = SIZE_WORD;
      bus.dma_req_i = 1'b0; bus.dma_we_i = 1'b0; bus.dma_addr_i = '0;
      bus.dma_wdata_i = '0; bus.dma_size_i = SIZE_WORD;
   endtask

   task automatic cpu_rd(input logic [31:0] a);
      bus.cpu_re_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = a;
   endtask

   task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
      bus.cpu_we_i = 1'b1; bus.cpu_re_i = 1'b0; bus.cpu_addr_i = a; bus.cpu_wdata_i = d;
   endtask

   task automatic dma_rd(input logic [31:0] a);
      bus.dma_req_i = 1'b1; bus.dma_we_i = 1'b0; bus.dma_addr_i = a;
   endtask

   // Inputs change just after the rising edge; outputs sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ram"}, {bus.ram_addr_o | bus.ram_wdata_o}, 32'h0);
      chk({tag, ".ctl"}, {26'h0, bus.ram_size_o, bus.ram_we_o, bus.ram_re_o, bus.cpu_hold_o}, 32'h0);
      chk({tag, ".gnt"}, {31'h0, bus.dma_gnt_o}, 32'h0);
      chk({tag, ".rv"},  {31'h0, bus.dma_rvalid_o}, 32'h0);
      chk({tag, ".rd"},  bus.cpu_rdata_o | bus.dma_rdata_o, 32'h0);
   endtask

   logic [31:0] alt_addr [0:3];
   logic        alt_dma  [0:3];

   initial begin
      alt_addr[0] = 32'h010; alt_dma[0] = 1'b0;
      alt_addr[1] = 32'h020; alt_dma[1] = 1'b1;
      alt_addr[2] = 32'h030; alt_dma[2] = 1'b0;
      alt_addr[3] = 32'h040; alt_dma[3] = 1'b1;

      // Requests present during reset must produce nothing.
      idle_all();
      cpu_rd(32'h100);
      dma_rd(32'h200);
      @(negedge clk);
      chk_all_zero("rst_hold");

      // First clock with rst=1 grants immediately.
      next_cycle();
      rst = 1'b1;
      idle_all();
      cpu_rd(32'h100);
      @(negedge clk);
      chk("c_rd.re",   {31'h0, bus.ram_re_o}, 32'h1);
      chk("c_rd.addr", bus.ram_addr_o, 32'h100);
      chk("c_rd.hold", {31'h0, bus.cpu_hold_o}, 32'h0);
      next_cycle();
      idle_all();
      @(negedge clk);
      chk("c_rd.data", bus.cpu_rdata_o, 32'hA000_0100);
      chk("c_rd.hold2", {31'h0, bus.cpu_hold_o}, 32'h0);

      // CPU write collides with DMA read: CPU first, DMA next cycle.
      next_cycle();
      cpu_wr(32'h300, 32'hDEAD_BEEF);
      dma_rd(32'h200);
      @(negedge clk);
      chk("col.we",   {31'h0, bus.ram_we_o}, 32'h1);
      chk("col.addr", bus.ram_addr_o, 32'h300);
      chk("col.hold", {31'h0, bus.cpu_hold_o}, 32'h0);
      chk("col.gnt",  {31'h0, bus.dma_gnt_o}, 32'h0);
      next_cycle();
      bus.cpu_we_i = 1'b0;
      @(negedge clk);
      chk("col.gnt2", {31'h0, bus.dma_gnt_o}, 32'h1);
      chk("col.addr2", bus.ram_addr_o, 32'h200);
      chk("col.re2",  {31'h0, bus.ram_re_o}, 32'h1);
      next_cycle();
      idle_all();
      @(negedge clk);
      chk("col.rv",   {31'h0, bus.dma_rvalid_o}, 32'h1);
      chk("col.rdat", bus.dma_rdata_o, 32'hA000_0200);
      chk("col.crd",  bus.cpu_rdata_o, 32'h0);

      // Write then read of the same word on consecutive cycles.
      next_cycle();
      cpu_wr(32'h104, 32'h1234_5678);
      next_cycle();
      cpu_rd(32'h104);
      next_cycle();
      idle_all();
      @(negedge clk);
      chk("wr_rd.data", bus.cpu_rdata_o, 32'h1234_5678);

      // Alternating reads, each return checked on the following cycle.
      for (int k = 0; k <= 4; k++) begin
         next_cycle();
         idle_all();
         if (k < 4) begin
            if (alt_dma[k]) dma_rd(alt_addr[k]);
            else            cpu_rd(alt_addr[k]);
         end
         @(negedge clk);
         if (k < 4) chk($sformatf("alt%0d.re", k), {31'h0, bus.ram_re_o}, 32'h1);
         if (k > 0) begin
            if (alt_dma[k-1]) begin
               chk($sformatf("alt%0d.rv", k), {31'h0, bus.dma_rvalid_o}, 32'h1);
               chk($sformatf("alt%0d.drd", k), bus.dma_rdata_o, 32'hA000_0000 | alt_addr[k-1]);
               chk($sformatf("alt%0d.crd", k), bus.cpu_rdata_o, 32'h0);
            end else begin
               chk($sformatf("alt%0d.rv", k), {31'h0, bus.dma_rvalid_o}, 32'h0);
               chk($sformatf("alt%0d.crd", k), bus.cpu_rdata_o, 32'hA000_0000 | alt_addr[k-1]);
               chk($sformatf("alt%0d.drd", k), bus.dma_rdata_o, 32'h0);
            end
         end
      end

      // CPU requesting every cycle with a DMA read pending.
`ifdef MEM_ARB_STARVE_GUARD_EN
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         idle_all();
         cpu_rd(32'h000);
         dma_rd(32'h200);
         @(negedge clk);
         chk($sformatf("guard%0d.gnt", c), {31'h0, bus.dma_gnt_o}, (c == 5) ? 32'h1 : 32'h0);
         chk($sformatf("guard%0d.hold", c), {31'h0, bus.cpu_hold_o}, (c == 5) ? 32'h1 : 32'h0);
      end
      next_cycle();
      bus.dma_req_i = 1'b0;
      @(negedge clk);
      chk("guard6.hold", {31'h0, bus.cpu_hold_o}, 32'h0);
      chk("guard6.addr", bus.ram_addr_o, 32'h000);
      chk("guard6.rv",   {31'h0, bus.dma_rvalid_o}, 32'h1);
      chk("guard6.rdat", bus.dma_rdata_o, 32'hA000_0200);
`else
      for (int c = 1; c <= 50; c++) begin
         next_cycle();
         idle_all();
         cpu_rd(32'h000);
         dma_rd(32'h200);
         @(negedge clk);
         chk($sformatf("starve%0d.gnt", c), {31'h0, bus.dma_gnt_o}, 32'h0);
         chk($sformatf("starve%0d.hold", c), {31'h0, bus.cpu_hold_o}, 32'h0);
      end
      next_cycle();
      bus.cpu_re_i = 1'b0;
      @(negedge clk);
      chk("starve.late", {31'h0, bus.dma_gnt_o}, 32'h1);
`endif

      // Reset the cycle after a DMA read grant: its return must vanish.
      next_cycle();
      idle_all();
      dma_rd(32'h040);
      @(negedge clk);
      chk("rr.gnt", {31'h0, bus.dma_gnt_o}, 32'h1);
      next_cycle();
      rst = 1'b0;
      cpu_rd(32'h100);
      @(negedge clk);
      chk_all_zero("rr.in1");
      next_cycle();
      @(negedge clk);
      chk_all_zero("rr.in2");
      next_cycle();
      rst = 1'b1;
      idle_all();
      @(negedge clk);
      chk("rr.rv_post", {31'h0, bus.dma_rvalid_o}, 32'h0);
      chk("rr.rd_post", bus.dma_rdata_o, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rr.rv_post2", {31'h0, bus.dma_rvalid_o}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
